// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
//   N_CH          : number of requesters / mux inputs
//   SEL_W         : width of the binary mux select
//   sched_state_t : scheduler FSM states
//   onehot_t      : one-hot grant vector
package mux_sched_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GUARD} sched_state_t;

  typedef logic [N_CH-1:0] onehot_t;

  // Binary select to one-hot enable for the AND-OR mux.
  function automatic onehot_t sel_to_onehot(input logic [SEL_W-1:0] s);
    return onehot_t'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
//   req : request vector, req[i] for channel i
//   ptr : channel that has highest priority this round
//   any : at least one request present
//   idx : first requesting channel in order ptr, ptr+1, ... (mod 4)
module rr_pick4
  import mux_sched_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 4:1 AND-OR mux between four requesters.
// A grant lasts HOLD_TICKS tick strobes (or until the owner drops its request),
// followed by a single guard cycle with no owner before re-arbitration.
//   clock, reset : clock and asynchronous active-high reset
//   tick         : hold-time pacing strobe, only counted while granting
//   req, data    : per-channel request and data bit
//   grant, sel   : registered one-hot owner and binary select of current/last owner
//   busy         : high while a channel owns the mux
//   y            : data bit of the current owner, 0 with no owner
// Optional: define MUX_RR_SCHEDULER_LOCK_EN to add a `lock` input that keeps the
// grant alive past hold expiry while the owner keeps requesting.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 3,
  parameter int unsigned CNT_W      = $clog2(HOLD_TICKS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
`ifdef MUX_RR_SCHEDULER_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  data,
  output onehot_t          grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y
);

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_TICKS - 1);

  sched_state_t     state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_lock;

`ifdef MUX_RR_SCHEDULER_LOCK_EN
  assign hold_lock = lock;
`else
  assign hold_lock = 1'b0;
`endif

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        // Guard re-arbitrates exactly like idle; ptr was already advanced.
        ST_IDLE, ST_GUARD: begin
          if (pick_any) begin
            state_q <= ST_GRANT;
            grant   <= sel_to_onehot(pick_idx);
            sel     <= pick_idx;
            busy    <= 1'b1;
            cnt_q   <= HOLD_INIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // A dropped request wins over any tick in the same cycle.
          if (!req[sel] || (tick && (cnt_q == '0) && !hold_lock)) begin
            state_q <= ST_GUARD;
            grant   <= '0;
            busy    <= 1'b0;
            ptr_q   <= sel + 1'b1;
          end else if (tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign y = |(grant & data);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Randomized scoreboard bench for mux_rr_scheduler with a behavioural model
// that tracks an owner channel and remaining hold ticks.
module tb_mux_rr_scheduler;

  localparam int HOLD = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b0;
  logic [3:0] req   = 4'b0;
  logic [3:0] data  = 4'b0;
`ifdef MUX_RR_SCHEDULER_LOCK_EN
  logic       lock  = 1'b0;
`endif
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  mux_rr_scheduler #(.HOLD_TICKS(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
`ifdef MUX_RR_SCHEDULER_LOCK_EN
    .lock  (lock),
`endif
    .req   (req),
    .data  (data),
    .grant (grant),
    .sel   (sel),
    .busy  (busy),
    .y     (y)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Model: owner channel (-1 = nobody), last owner, rotation start, ticks left.
  int m_owner, m_last, m_ptr, m_left;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_left  = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic t, input logic lk);
    bit found;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!found && r[c]) begin
          found   = 1;
          m_owner = c;
          m_last  = c;
          m_left  = HOLD;
        end
      end
    end else if (!r[m_owner] || (t && m_left == 1 && !lk)) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (t && m_left > 1) begin
      m_left = m_left - 1;
    end
  endtask

  function automatic exp_t model_out(input logic [3:0] d);
    exp_t e;
    e.grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sel   = 2'(m_last);
    e.busy  = (m_owner >= 0);
    e.y     = |(e.grant & d);
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " grant"}, 8'(grant), 8'h0);
    check({tag, " sel"},   8'(sel),   8'h0);
    check({tag, " busy"},  8'(busy),  8'h0);
    check({tag, " y"},     8'(y),     8'h0);
  endtask

  // Monitor: compares every presented output against the queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("grant", 8'(grant), 8'(e.grant));
        check("sel",   8'(sel),   8'(e.sel));
        check("busy",  8'(busy),  8'(e.busy));
        check("y",     8'(y),     8'(e.y));
      end
    end
  end

  // Driver: drives inputs just after each rising edge and queues the model's answer.
  initial begin
    int hold_cnt;
    int resets_done;
    model_reset();
    hold_cnt    = 0;
    resets_done = 0;
    req  = 4'b1111;
    data = 4'b1111;
    #2 reset = 1'b1;
    #1 check_cleared("async reset");
    repeat (2) @(posedge clock);
    #1 check_cleared("held reset");
    @(negedge clock);
    #1 reset = 1'b0;

    for (int n = 0; n < 1500; n++) begin
      @(posedge clock);
      #1;
`ifdef MUX_RR_SCHEDULER_LOCK_EN
      model_step(req, tick, lock);
`else
      model_step(req, tick, 1'b0);
`endif
      if (n < 60) begin
        req  = 4'b1111;
        tick = (n % 4 == 3);
      end else if (n < 100) begin
        req  = 4'b0100;
        tick = (n % 4 == 3);
      end else begin
        if (hold_cnt == 0) begin
          req      = 4'($urandom);
          hold_cnt = $urandom_range(1, 16);
        end else begin
          int b;
          hold_cnt--;
          b = $urandom_range(0, 3);
          if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
        end
        tick = (n < 700) ? (n % 4 == 3) : ($urandom_range(0, 3) == 0);
`ifdef MUX_RR_SCHEDULER_LOCK_EN
        if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
      end
      data = 4'($urandom);
      sb.push_back(model_out(data));

      // Asynchronous reset between edges while a channel holds the mux.
      if (n >= 300 && m_owner >= 0 && resets_done < 3 && (n % 200 < 20)) begin
        @(negedge clock);
        #1 reset = 1'b1;
        data = 4'b1111;
        #1 check_cleared("mid-grant reset");
        #1 reset = 1'b0;
        model_reset();
        req      = 4'b1001;
        hold_cnt = 6;
        resets_done++;
      end
    end

    @(negedge clock);
    #1;
    check("reset pulses issued", 8'(resets_done > 0), 8'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin arbiter that shares the 4→1 decoder/AND-OR mux between four requesters.
- Drives the mux select (`sel`) and its one-hot enable (`grant`), and holds each grant for a programmable number of slow ticks.
- Inserts a one-cycle guard gap between owners and produces the selected data bit.
- Sits between the key/GPIO request sources and the mux datapath in `hackathon_top`; its outputs also feed the LEDs.

Parameters:
- `HOLD_TICKS`, default 3: number of `tick` pulses a grant lasts. Legal range 1..255.
- `CNT_W`, default `$clog2(HOLD_TICKS+1)`: width of the hold counter. Derived; do not override.

Ports:
- `clock`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `tick`  input  1  single-cycle enable strobe that paces hold time (e.g. synchronised `slow_clock` edge).
- `req`  input  4  request per channel, level-sensitive; `req[i]` requests channel i.
- `data`  input  4  data bit per channel.
- `grant`  output  4  one-hot owner, registered; `0000` when no owner.
- `sel`  output  2  binary index of the current or last owner, registered.
- `busy`  output  1  high while in GRANT.
- `y`  output  1  `|(grant & data)`, combinational from registered `grant`; 0 when `grant==0`.

Behaviour:
- Reset (asynchronous, active-high), all applied immediately with no clock edge needed:
  - state = IDLE
  - `grant` = 0000, `sel` = 00, `busy` = 0, `y` = 0
  - `ptr` = 0, hold counter = 0
- `ptr` is a 2-bit rotating start index for arbitration.
- Arbitration (`pick`): the first i in order `ptr`, `ptr+1`, … (mod 4) with `req[i]==1`.
- IDLE:
  - If `req != 0`, on the next edge: go to GRANT, `grant = 1<<pick`, `sel = pick`, counter = `HOLD_TICKS-1`.
  - Latency: `req` high in cycle n → `grant` visible in cycle n+1.
- GRANT:
  - If `req[sel]==0`: go to GUARD.
  - Else if `tick` and counter == 0: go to GUARD.
  - Else if `tick`: counter decrements.
  - `tick` together with the owner dropping its request → GUARD (drop wins; same outcome).
- GUARD (exactly one cycle):
  - `grant` = 0000, `busy` = 0, `sel` keeps its value.
  - `ptr` = `sel+1` (wraps 3→0).
  - Next edge: re-arbitrate with the new `ptr`. Any request → GRANT (gap is exactly one cycle); none → IDLE.
- `tick` is ignored in IDLE and GUARD.
- Fairness: a lone requester is re-granted after each guard cycle. With all four requesting, order is 0,1,2,3,0…
- `grant` is always one-hot or zero.
- Requests arriving mid-grant are not sampled until GUARD.
- Reset mid-grant: `grant` clears asynchronously; after release, arbitration restarts from `ptr` = 0.

Optional Feature:
- Macro: `MUX_RR_SCHEDULER_LOCK_EN`.
- When defined:
  - Adds input port `lock` (1 bit).
  - While in GRANT with `lock==1` and `req[sel]==1`, hold expiry is suppressed: the counter saturates at 0 and the grant persists.
  - Dropping `req[sel]` still ends the grant.
  - `lock` has no effect outside GRANT.
- When undefined: no `lock` port; behaviour exactly as above.

Decomposition:
- Package `mux_sched_pkg`:
  - `N_CH` = 4, `SEL_W` = 2.
  - `typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GUARD} sched_state_t`.
  - `typedef logic [N_CH-1:0] onehot_t`.
- Sub-module `rr_pick4`: combinational rotating-priority picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `any`, `idx[1:0]`.
  - Instantiated once.

Test Plan (`HOLD_TICKS`=3, `tick` every 4th cycle unless stated):
1. Reset asserted, `req`=1111 → `grant`=0000, `sel`=00, `busy`=0, `y`=0; after release, `grant`=0001 one cycle later.
2. `req`=0100 held → `grant`=0100 / `sel`=10 at n+1; cleared after the 3rd tick; one guard cycle at 0000; then 0100 again.
3. `req`=1111 held → `grant` sequence 0001, 0010, 0100, 1000, 0001, each lasting 3 ticks, separated by one-cycle 0000 gaps.
4. Owner 0010, `req` changes 1010→1000 mid-hold → `grant`=0000 next cycle, then 1000; tick and drop in the same cycle gives the same result.
5. `grant`=0100: `data`=0100 → `y`=1; `data`=1011 → `y`=0; in GUARD with `data`=1111 → `y`=0.
6. Reset pulsed between clock edges during `grant`=1000 → `grant`=0000 with no edge; after release, `req`=1001 → `grant`=0001 (`ptr` back to 0). With `LOCK_EN` defined and `lock`=1: grant persists past 10 ticks until `req[sel]` drops.
